// File: rtl/score_pkg.sv
`default_nettype none
// ============================================================================
// Module   : score_pkg
// Brief    : Shared widths, score limit, FSM encoding and clamped score update
// Revision : 1.0  initial release
// ============================================================================
package score_pkg;

    localparam int SCORE_MAX = 999;
    localparam int SCORE_W   = 11;
    localparam int TIME_W    = 7;
    localparam int ARITH_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    // Applies the net change, then clamps it to 0..SCORE_MAX so the score never wraps.
    function automatic logic [SCORE_W-1:0] apply_delta(
        input logic [SCORE_W-1:0] cur,
        input logic [ARITH_W-1:0] add,
        input logic [ARITH_W-1:0] sub
    );
        logic [ARITH_W-1:0] up;
        up = ARITH_W'(cur) + add;
        if (up <= sub) begin
            up = '0;
        end else begin
            up = up - sub;
        end
        if (up > ARITH_W'(SCORE_MAX)) begin
            up = ARITH_W'(SCORE_MAX);
        end
        return SCORE_W'(up);
    endfunction

endpackage
`default_nettype wire

// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : input_debouncer
// Brief    : 2-flop synchronizer, counting debouncer and one-cycle rise pulse
// Revision : 1.0  initial release
// ============================================================================
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 100_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_level;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;

    // Counter holds the number of consecutive samples that disagreed with the level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_meta <= raw;
            r_sync <= r_meta;
            r_rise <= 1'b0;
            if (r_sync == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_last_cnt) begin
                r_cnt   <= '0;
                r_level <= r_sync;
                r_rise  <= r_sync;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// Module   : score_keeper
// Brief    : Timed game round with debounced start/hit inputs and clamped score.
//            Optional macro SCORE_PENALTY_EN adds the miss_in penalty input.
// Revision : 1.0  initial release
// ============================================================================
module score_keeper
    import score_pkg::*;
#(
    parameter int CLK_HZ          = 10_000_000,
    parameter int DEBOUNCE_CYCLES = 100_000,
    parameter int GAME_SECONDS    = 60,
    parameter int HIT_POINTS      = 10,
    parameter int MISS_POINTS     = 5
) (
    input  logic               CLOCK10M,
    input  logic               RESET,
    input  logic               start_btn,
    input  logic               hit_in,
`ifdef SCORE_PENALTY_EN
    input  logic               miss_in,
`endif
    output logic [SCORE_W-1:0] score,
    output logic [TIME_W-1:0]  time_left,
    output logic               game_active,
    output logic               hit_ack
);

    localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0]   c_pre_last  = PRE_W'(CLK_HZ - 1);
    localparam logic [TIME_W-1:0]  c_game_time = TIME_W'(GAME_SECONDS);
    localparam logic [ARITH_W-1:0] c_hit_pts   = ARITH_W'(HIT_POINTS);
    localparam logic [ARITH_W-1:0] c_miss_pts  = ARITH_W'(MISS_POINTS);

    state_t              r_state;
    state_t              w_state_next;
    logic [SCORE_W-1:0]  r_score;
    logic [TIME_W-1:0]   r_time;
    logic [PRE_W-1:0]    r_presc;
    logic                r_hit_ack;

    logic                w_start_ev;
    logic                w_hit_ev;
    logic                w_miss_ev;
    logic                w_tick;
    logic                w_game_active;
    logic [ARITH_W-1:0]  w_add;
    logic [ARITH_W-1:0]  w_sub;

    input_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_start_db (
        .clk  (CLOCK10M),
        .rst  (RESET),
        .raw  (start_btn),
        .rise (w_start_ev)
    );

    input_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_hit_db (
        .clk  (CLOCK10M),
        .rst  (RESET),
        .raw  (hit_in),
        .rise (w_hit_ev)
    );

`ifdef SCORE_PENALTY_EN
    input_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_miss_db (
        .clk  (CLOCK10M),
        .rst  (RESET),
        .raw  (miss_in),
        .rise (w_miss_ev)
    );
`else
    assign w_miss_ev = 1'b0;
`endif

    assign w_tick = (r_state == RUN) && (r_presc == c_pre_last);
    assign w_add  = w_hit_ev  ? c_hit_pts  : '0;
    assign w_sub  = w_miss_ev ? c_miss_pts : '0;

    always_ff @(posedge CLOCK10M) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_game_active = 1'b0;
        case (r_state)
            IDLE, OVER: begin
                if (w_start_ev) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_game_active = 1'b1;
                if (w_tick && (r_time == TIME_W'(1))) begin
                    w_state_next = OVER;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Outside RUN the score and timer only change when a new round starts.
    always_ff @(posedge CLOCK10M) begin
        if (RESET) begin
            r_score   <= '0;
            r_time    <= '0;
            r_presc   <= '0;
            r_hit_ack <= 1'b0;
        end else begin
            r_hit_ack <= 1'b0;
            if (r_state == RUN) begin
                r_presc   <= w_tick ? '0 : r_presc + PRE_W'(1);
                r_hit_ack <= w_hit_ev;
                if (w_tick) begin
                    r_time <= r_time - TIME_W'(1);
                end
                if (w_hit_ev || w_miss_ev) begin
                    r_score <= apply_delta(r_score, w_add, w_sub);
                end
            end else if (w_start_ev) begin
                r_score <= '0;
                r_time  <= c_game_time;
                r_presc <= '0;
            end
        end
    end

    assign score       = r_score;
    assign time_left   = r_time;
    assign game_active = w_game_active;
    assign hit_ack     = r_hit_ack;

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// Directed bench for score_keeper: round timing, debounce, saturation, reset and penalty.
module tb_score_keeper;
    import score_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_btn = 1'b0;
    logic hit_in = 1'b0;
`ifdef SCORE_PENALTY_EN
    logic miss_in = 1'b0;
`endif
    logic start2 = 1'b0;
    logic hit2 = 1'b0;

    logic [SCORE_W-1:0] score, score2;
    logic [TIME_W-1:0]  time_left, time2;
    logic               game_active, active2, hit_ack, ack2;

    int n_checks = 0;
    int n_fails  = 0;
    int acks     = 0;
    int acks2    = 0;
    int t        = 0;

    always #5 clk = ~clk;

    score_keeper #(
        .CLK_HZ(20), .DEBOUNCE_CYCLES(4), .GAME_SECONDS(3), .HIT_POINTS(10), .MISS_POINTS(5)
    ) dut (
        .CLOCK10M    (clk),
        .RESET       (rst),
        .start_btn   (start_btn),
        .hit_in      (hit_in),
`ifdef SCORE_PENALTY_EN
        .miss_in     (miss_in),
`endif
        .score       (score),
        .time_left   (time_left),
        .game_active (game_active),
        .hit_ack     (hit_ack)
    );

    // Long round so that 100+ hits fit before the timer expires.
    score_keeper #(
        .CLK_HZ(20), .DEBOUNCE_CYCLES(4), .GAME_SECONDS(99), .HIT_POINTS(10), .MISS_POINTS(5)
    ) dut_long (
        .CLOCK10M    (clk),
        .RESET       (rst),
        .start_btn   (start2),
        .hit_in      (hit2),
`ifdef SCORE_PENALTY_EN
        .miss_in     (1'b0),
`endif
        .score       (score2),
        .time_left   (time2),
        .game_active (active2),
        .hit_ack     (ack2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            t++;
            if (hit_ack) acks++;
        end
    endtask

    task automatic wait_until(input int target);
        if (target > t) wait_edges(target - t);
    endtask

    task automatic drive_hit(input int hi, input int lo);
        hit_in = 1'b1;
        wait_edges(hi);
        hit_in = 1'b0;
        wait_edges(lo);
    endtask

    // Holds start for 10 cycles; t ends as the number of edges since RUN was entered.
    task automatic start_round();
        int since;
        since = -1;
        start_btn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (hit_ack) acks++;
            if (since >= 0) since++;
            else if (game_active) since = 0;
        end
        start_btn = 1'b0;
        check_eq("round_start", {31'b0, since >= 0}, 32'd1);
        t = (since < 0) ? 0 : since;
    endtask

    task automatic hit2_pulse();
        hit2 = 1'b1;
        repeat (6) begin @(posedge clk); @(negedge clk); if (ack2) acks2++; end
        hit2 = 1'b0;
        repeat (6) begin @(posedge clk); @(negedge clk); if (ack2) acks2++; end
    endtask

    initial begin
        // Start already high while reset releases must not fire early.
        start_btn = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_edges(4);
        check_eq("no_early_start", game_active, 0);
        start_btn = 1'b0;
        rst = 1'b1;
        wait_edges(2);
        rst = 1'b0;
        wait_edges(1);
        check_eq("rst_score", score, 0);
        check_eq("rst_time", time_left, 0);
        check_eq("rst_active", game_active, 0);
        check_eq("rst_ack", hit_ack, 0);
        check_eq("rst_state", dut.r_state, IDLE);

        // Round 1: timer
        start_round();
        check_eq("r1_time3", time_left, 3);
        check_eq("r1_score0", score, 0);
        check_eq("r1_active", game_active, 1);
        wait_until(19);
        check_eq("r1_time_pre_tick", time_left, 3);
        wait_until(20);
        check_eq("r1_time2", time_left, 2);
        wait_until(40);
        check_eq("r1_time1", time_left, 1);
        wait_until(59);
        check_eq("r1_active_last", game_active, 1);
        wait_until(60);
        check_eq("r1_time0", time_left, 0);
        check_eq("r1_inactive", game_active, 0);
        check_eq("r1_state_over", dut.r_state, OVER);
        wait_edges(5);
        check_eq("r1_time_hold", time_left, 0);

        // Round 2: glitches rejected, long hold scores once
        start_round();
        check_eq("r2_time3", time_left, 3);
        acks = 0;
        drive_hit(2, 6);
        drive_hit(2, 6);
        check_eq("glitch_score", score, 0);
        check_eq("glitch_acks", acks, 0);
        drive_hit(30, 6);
        check_eq("hold_acks", acks, 1);
        check_eq("hold_score", score, 10);
        wait_until(62);
        check_eq("r2_over", dut.r_state, OVER);

        // Round 3: hit coincident with the final tick
        start_round();
        check_eq("r3_score0", score, 0);
        wait_until(53);
        acks = 0;
        hit_in = 1'b1;
        wait_until(60);
        check_eq("final_hit_score", score, 10);
        check_eq("final_hit_ack", hit_ack, 1);
        check_eq("final_inactive", game_active, 0);
        check_eq("final_state", dut.r_state, OVER);
        wait_edges(6);
        hit_in = 1'b0;
        wait_edges(6);
        drive_hit(6, 6);
        check_eq("over_hit_score", score, 10);
        check_eq("over_hit_acks", acks, 1);
        check_eq("over_time", time_left, 0);

        // Round 4: restart, reach 40, reset mid-round
        start_round();
        check_eq("r4_score0", score, 0);
        check_eq("r4_time3", time_left, 3);
        for (int i = 0; i < 4; i++) drive_hit(6, 6);
        check_eq("r4_score40", score, 40);
        check_eq("r4_active", game_active, 1);
        rst = 1'b1;
        wait_edges(1);
        check_eq("mid_rst_score", score, 0);
        check_eq("mid_rst_time", time_left, 0);
        check_eq("mid_rst_active", game_active, 0);
        check_eq("mid_rst_state", dut.r_state, IDLE);
        rst = 1'b0;
        wait_edges(2);

`ifdef SCORE_PENALTY_EN
        start_round();
        acks = 0;
        miss_in = 1'b1;
        wait_edges(6);
        miss_in = 1'b0;
        wait_edges(6);
        check_eq("miss_at_zero", score, 0);
        check_eq("miss_no_ack", acks, 0);
        drive_hit(6, 6);
        check_eq("pen_score10", score, 10);
        hit_in = 1'b1;
        miss_in = 1'b1;
        wait_edges(6);
        hit_in = 1'b0;
        miss_in = 1'b0;
        wait_edges(6);
        check_eq("hit_and_miss", score, 15);
        check_eq("hit_and_miss_acks", acks, 2);
`endif

        // Saturation on the long-round instance
        start2 = 1'b1;
        repeat (10) begin @(posedge clk); @(negedge clk); end
        start2 = 1'b0;
        check_eq("long_active", active2, 1);
        check_eq("long_time", time2, 99);
        for (int i = 0; i < 99; i++) hit2_pulse();
        check_eq("sat_990", score2, 990);
        hit2_pulse();
        check_eq("sat_999", score2, 999);
        check_eq("sat_acks", acks2, 100);
        hit2_pulse();
        hit2_pulse();
        check_eq("sat_hold", score2, 999);
        check_eq("long_still_active", active2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
